// File: rtl/demux_pkg.sv
// Shared types and decode helper for the registered 1-to-N demultiplexer.
// The decode is sized to the widest supported lane count; callers slice what they need.
package demux_pkg;

  localparam int DEMUX_MAX_OUT = 16;
  localparam int LANE_IDX_W    = $clog2(DEMUX_MAX_OUT);

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  // One-hot of sel over n lanes; all-zero when sel does not name a real lane.
  function automatic logic [DEMUX_MAX_OUT-1:0] onehot_dec(input lane_idx_t sel, input int n);
    logic [DEMUX_MAX_OUT-1:0] dec;
    dec = '0;
    if (int'(sel) < n) dec[sel] = 1'b1;
    return dec;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational binary-to-one-hot lane decoder with an in-range flag.
// An out-of-range select yields an all-zero one-hot and in_range low.
module onehot_decoder
  import demux_pkg::*;
#(
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 2
) (
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] onehot,
  output logic               in_range
);

  lane_idx_t                sel_idx;
  logic [DEMUX_MAX_OUT-1:0] dec_full;

  always_comb begin
    sel_idx  = lane_idx_t'(sel);
    dec_full = onehot_dec(sel_idx, NUM_OUT);
  end

  // Lanes beyond NUM_OUT are never set, so the OR over the full decode is the range check.
  assign onehot   = dec_full[NUM_OUT-1:0];
  assign in_range = |dec_full;

endmodule

// File: rtl/demux_1to4.sv
// Registered 1-to-NUM_OUT demultiplexer: In is steered to lane Sel, all other lanes
// are zero, with one clock of latency and a registered out-of-range select flag.
module demux_1to4
  import demux_pkg::*;
#(
  parameter int DATA_W  = 1,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         In,
  input  logic [SEL_W-1:0]          Sel,
  output logic [NUM_OUT*DATA_W-1:0] Out,
  output logic                      sel_err
);

  if (SEL_W != $clog2(NUM_OUT)) begin : g_bad_sel_w
    $error("demux_1to4: SEL_W must equal $clog2(NUM_OUT)");
  end
  if (NUM_OUT < 2 || NUM_OUT > DEMUX_MAX_OUT) begin : g_bad_num_out
    $error("demux_1to4: NUM_OUT must be in 2..16");
  end

  logic [NUM_OUT-1:0]        onehot_p0;
  logic                      in_range_p0;
  logic [NUM_OUT*DATA_W-1:0] lanes_p0;
  logic [NUM_OUT*DATA_W-1:0] out_p1;
  logic                      sel_err_p1;

  onehot_decoder #(
    .NUM_OUT (NUM_OUT),
    .SEL_W   (SEL_W)
  ) u_dec (
    .sel      (Sel),
    .onehot   (onehot_p0),
    .in_range (in_range_p0)
  );

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
    assign lanes_p0[k*DATA_W +: DATA_W] = In & {DATA_W{onehot_p0[k]}};
  end

  // p0 -> p1: every edge captures a fresh sample; nothing from earlier samples is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p1     <= '0;
      sel_err_p1 <= 1'b0;
    end else begin
      out_p1     <= lanes_p0;
      sel_err_p1 <= ~in_range_p0;
    end
  end

  assign Out     = out_p1;
  assign sel_err = sel_err_p1;

endmodule

// File: tb/tb_demux_1to4.sv
// Bench for demux_1to4: a default 1-bit x 4 instance and an 8-bit x 3 instance,
// checked by a scoreboard fed from an arithmetic reference model.
module tb_demux_1to4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_a;
  logic [1:0]  sel_a;
  logic [3:0]  out_a;
  logic        err_a;
  logic [7:0]  in_b;
  logic [1:0]  sel_b;
  logic [23:0] out_b;
  logic        err_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] out;
    logic        err;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;

  always #5 clk = ~clk;

  demux_1to4 u_dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .In      (in_a),
    .Sel     (sel_a),
    .Out     (out_a),
    .sel_err (err_a)
  );

  demux_1to4 #(
    .DATA_W  (8),
    .NUM_OUT (3),
    .SEL_W   (2)
  ) u_dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .In      (in_b),
    .Sel     (sel_b),
    .Out     (out_b),
    .sel_err (err_b)
  );

  // Reference: the data word shifted to its lane position, or nothing if the lane does not exist.
  function automatic exp_t model(input longint unsigned data, input int sel, input int n, input int w);
    exp_t e;
    if (sel < n) begin
      e.out = 64'(data << (sel * w));
      e.err = 1'b0;
    end else begin
      e.out = '0;
      e.err = 1'b1;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      check("a_out", 64'(out_a), ea.out);
      check("a_err", 64'(err_a), 64'(ea.err));
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      check("b_out", 64'(out_b), eb.out);
      check("b_err", 64'(err_b), 64'(eb.err));
    end
  end

  task automatic drive_a(input logic d, input logic [1:0] s);
    @(negedge clk);
    in_a  = d;
    sel_a = s;
    qa.push_back(model(64'(d), int'(s), 4, 1));
  endtask

  task automatic drive_b(input logic [7:0] d, input logic [1:0] s);
    @(negedge clk);
    in_b  = d;
    sel_b = s;
    qb.push_back(model(64'(d), int'(s), 3, 8));
  endtask

  initial begin
    rst_n = 1'b1;
    in_a  = 1'b1;
    sel_a = 2'b10;
    in_b  = 8'hA5;
    sel_b = 2'd1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_a_out", 64'(out_a), 64'h0);
    check("reset_a_err", 64'(err_a), 64'h0);
    check("reset_b_out", 64'(out_b), 64'h0);
    check("reset_b_err", 64'(err_b), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_a", 64'(out_a), 64'h0);
    check("reset_hold_b", 64'(out_b), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int s = 0; s < 4; s++) drive_a(1'b1, 2'(s));
    for (int s = 0; s < 4; s++) drive_a(1'b0, 2'(s));

    drive_b(8'hA5, 2'd1);
    drive_b(8'hA5, 2'd3);
    drive_b(8'hA5, 2'd0);

    drive_a(1'b1, 2'b11);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_a_out", 64'(out_a), 64'h0);
    check("midrst_a_err", 64'(err_a), 64'h0);
    check("midrst_b_out", 64'(out_b), 64'h0);
    #1 rst_n = 1'b1;
    qa.push_back(model(64'(in_a), int'(sel_a), 4, 1));
    qb.push_back(model(64'(in_b), int'(sel_b), 3, 8));

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      in_a  = 1'($urandom);
      sel_a = 2'($urandom_range(0, 3));
      in_b  = 8'($urandom);
      sel_b = 2'($urandom_range(0, 3));
      qa.push_back(model(64'(in_a), int'(sel_a), 4, 1));
      qb.push_back(model(64'(in_b), int'(sel_b), 3, 8));
    end

    repeat (2) @(posedge clk);
    #2;
    check("drain", 64'(qa.size() + qb.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
